// File: rtl/async_fifo_rd_ctrl.sv
// Read-domain controller for the dual-clock FIFO: write-pointer synchroniser, read pointer,
// RAM read port and standard or first-word-fall-through presentation with occupancy flags.
module async_fifo_rd_ctrl #(
    parameter int DEPTH       = 8,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2,
    parameter int FWFT        = 1
) (
    input  logic                       rd_clk,
    input  logic                       reset,
    input  logic [$clog2(DEPTH):0]     wr_ptr_gray,
    output logic [$clog2(DEPTH):0]     rd_ptr_gray,
    output logic [$clog2(DEPTH)-1:0]   ram_raddr,
    output logic                       ram_ren,
    input  logic [WIDTH-1:0]           ram_rdata,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH)+1:0]   rd_count,
    output logic                       underflow
);

    localparam int AW        = $clog2(DEPTH);
    localparam bit FWFT_MODE = (FWFT != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t           state_q;
    logic [AW:0]      sync_q [SYNC_STAGES];
    logic [AW:0]      wr_bin_s;
    logic [AW:0]      rd_ptr_bin;
    logic [AW:0]      rd_ptr_next;
    logic [AW:0]      ram_level;
    logic             ram_avail;
    logic             issue;
    logic             rd_valid_q;
    logic [WIDTH-1:0] hold_q;

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        for (int i = 0; i <= AW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    assign wr_bin_s    = gray2bin(sync_q[SYNC_STAGES-1]);
    assign ram_avail   = (wr_bin_s != rd_ptr_bin);
    assign ram_level   = wr_bin_s - rd_ptr_bin;
    assign rd_ptr_next = rd_ptr_bin + {{AW{1'b0}}, issue};
    assign ram_raddr   = rd_ptr_bin[AW-1:0];
    assign ram_ren     = issue;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        issue = 1'b0;
        if (reset) begin
            if (FWFT_MODE) begin
                issue = ram_avail && ((state_q == S_IDLE) || rd_en);
            end else begin
                issue = ram_avail && rd_en;
            end
        end
    end

    // The registered RAM output is only meaningful the cycle after a read; HOLD replays the captured copy.
    always_comb begin
        rd_data = '0;
        if (state_q == S_HOLD) begin
            rd_data = hold_q;
        end else if (rd_valid_q) begin
            rd_data = ram_rdata;
        end
    end

    assign rd_valid = rd_valid_q;

    always_comb begin
        rd_count = {1'b0, ram_level};
        empty    = !ram_avail;
        if (FWFT_MODE) begin
            rd_count = {1'b0, ram_level} + {{(AW + 1){1'b0}}, rd_valid_q};
            empty    = !rd_valid_q;
        end
    end

    assign almost_empty = (rd_count <= (AW + 2)'(AE_THRESH));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, which the synchroniser chain depends on.
    always_ff @(posedge rd_clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            rd_ptr_bin  <= '0;
            rd_ptr_gray <= '0;
            state_q     <= S_IDLE;
            rd_valid_q  <= 1'b0;
            hold_q      <= '0;
            underflow   <= 1'b0;
        end else begin
            sync_q[0] <= wr_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            rd_ptr_bin  <= rd_ptr_next;
            rd_ptr_gray <= rd_ptr_next ^ (rd_ptr_next >> 1);

            if (FWFT_MODE) begin
                underflow <= rd_en && !rd_valid_q;
                case (state_q)
                    S_IDLE: begin
                        if (ram_avail) begin
                            state_q    <= S_FETCH;
                            rd_valid_q <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        if (!rd_en) begin
                            hold_q  <= ram_rdata;
                            state_q <= S_HOLD;
                        end else if (!ram_avail) begin
                            state_q    <= S_IDLE;
                            rd_valid_q <= 1'b0;
                        end
                    end
                    S_HOLD: begin
                        if (rd_en) begin
                            if (ram_avail) begin
                                state_q <= S_FETCH;
                            end else begin
                                state_q    <= S_IDLE;
                                rd_valid_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q    <= S_IDLE;
                        rd_valid_q <= 1'b0;
                    end
                endcase
            end else begin
                underflow  <= rd_en && !ram_avail;
                rd_valid_q <= issue;
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Bench for async_fifo_rd_ctrl: an FWFT and a standard-mode instance share the write pointer,
// with directed scenarios and a randomized run against an occupancy/ordering reference model.
module tb_async_fifo_rd_ctrl;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int AE    = 2;
    localparam int AW    = 3;

    logic rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    logic             reset;
    logic [AW:0]      wr_ptr_gray;
    logic             rd_en_f, rd_en_s;

    logic [AW:0]      f_rd_ptr_gray, s_rd_ptr_gray;
    logic [AW-1:0]    f_raddr, s_raddr;
    logic             f_ren, s_ren;
    logic [WIDTH-1:0] f_rdata = '0;
    logic [WIDTH-1:0] s_rdata = '0;
    logic [WIDTH-1:0] f_data, s_data;
    logic             f_valid, s_valid, f_empty, s_empty, f_ae, s_ae, f_uf, s_uf;
    logic [AW+1:0]    f_count, s_count;

    logic [WIDTH-1:0] mem  [DEPTH];
    logic [WIDTH-1:0] dlog [512];

    int n_cmp = 0;
    int n_bad = 0;

    async_fifo_rd_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .AE_THRESH(AE), .FWFT(1)) u_fw (
        .rd_clk(rd_clk), .reset(reset), .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(f_rd_ptr_gray),
        .ram_raddr(f_raddr), .ram_ren(f_ren), .ram_rdata(f_rdata), .rd_en(rd_en_f), .rd_data(f_data),
        .rd_valid(f_valid), .empty(f_empty), .almost_empty(f_ae), .rd_count(f_count), .underflow(f_uf)
    );

    async_fifo_rd_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .AE_THRESH(AE), .FWFT(0)) u_st (
        .rd_clk(rd_clk), .reset(reset), .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(s_rd_ptr_gray),
        .ram_raddr(s_raddr), .ram_ren(s_ren), .ram_rdata(s_rdata), .rd_en(rd_en_s), .rd_data(s_data),
        .rd_valid(s_valid), .empty(s_empty), .almost_empty(s_ae), .rd_count(s_count), .underflow(s_uf)
    );

    // Registered-read RAM; output is garbage in any cycle not preceded by a read strobe.
    always @(posedge rd_clk) begin
        f_rdata <= f_ren ? mem[f_raddr] : WIDTH'($urandom);
        s_rdata <= s_ren ? mem[s_raddr] : WIDTH'($urandom);
    end

    function automatic logic [AW:0] to_gray(input int n);
        logic [AW:0] b;
        b = n[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; rd_en_f = 1'b0; rd_en_s = 1'b0; wr_ptr_gray = '0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; rd_en_f = 1'b1; rd_en_s = 1'b1; wr_ptr_gray = 4'b0101;
        repeat (3) tick();
        n_cmp++; if (f_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", f_valid); end
        n_cmp++; if (f_uf !== 1'b0) begin n_bad++; $display("FAIL rst_underflow: got %b want 0", f_uf); end
        n_cmp++; if (f_count !== 5'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", f_count); end
        n_cmp++; if (f_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b want 1", f_empty); end
        n_cmp++; if (f_ae !== 1'b1) begin n_bad++; $display("FAIL rst_almost_empty: got %b want 1", f_ae); end
        n_cmp++; if (f_ren !== 1'b0 || s_ren !== 1'b0) begin n_bad++; $display("FAIL rst_ram_ren: got %b/%b want 0/0", f_ren, s_ren); end
        n_cmp++; if (f_rd_ptr_gray !== 4'b0000) begin n_bad++; $display("FAIL rst_rd_ptr_gray: got %b want 0000", f_rd_ptr_gray); end
        n_cmp++; if (f_data !== 8'h00) begin n_bad++; $display("FAIL rst_rd_data: got %h want 00", f_data); end
        n_cmp++; if (s_uf !== 1'b0 || s_empty !== 1'b1) begin n_bad++; $display("FAIL rst_std_flags: got uf=%b empty=%b want 0/1", s_uf, s_empty); end
        reset = 1'b1; rd_en_f = 1'b0; rd_en_s = 1'b0;
        tick();
        tick();
        n_cmp++; if (f_valid !== 1'b0) begin n_bad++; $display("FAIL rst_early_valid: got %b want 0", f_valid); end
        n_cmp++; if (s_count !== 5'd6 || s_empty !== 1'b0) begin n_bad++; $display("FAIL rst_std_level: got %0d/%b want 6/0", s_count, s_empty); end
        tick();
        n_cmp++; if (f_valid !== 1'b1 || f_count !== 5'd6) begin n_bad++; $display("FAIL rst_release: got valid=%b count=%0d want 1/6", f_valid, f_count); end
    endtask

    task automatic test_fwft_first();
        do_reset();
        mem[0] = 8'hA5;
        wr_ptr_gray = 4'b0001;
        tick();
        tick();
        n_cmp++; if (f_valid !== 1'b0) begin n_bad++; $display("FAIL ff_edge2_valid: got %b want 0", f_valid); end
        n_cmp++; if (f_ren !== 1'b1 || f_raddr !== 3'd0) begin n_bad++; $display("FAIL ff_fetch: got ren=%b addr=%0d want 1/0", f_ren, f_raddr); end
        tick();
        n_cmp++; if (f_valid !== 1'b1 || f_data !== 8'hA5) begin n_bad++; $display("FAIL ff_first: got %b/%h want 1/a5", f_valid, f_data); end
        n_cmp++; if (f_count !== 5'd1 || f_empty !== 1'b0 || f_ae !== 1'b1) begin n_bad++; $display("FAIL ff_status: got cnt=%0d e=%b ae=%b want 1/0/1", f_count, f_empty, f_ae); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (f_valid !== 1'b1 || f_data !== 8'hA5) begin n_bad++; $display("FAIL ff_hold%0d: got %b/%h want 1/a5", k, f_valid, f_data); end
        end
        rd_en_f = 1'b1;
        tick();
        n_cmp++; if (f_valid !== 1'b0 || f_empty !== 1'b1 || f_uf !== 1'b0 || f_count !== 5'd0) begin
            n_bad++; $display("FAIL ff_pop: got v=%b e=%b uf=%b cnt=%0d want 0/1/0/0", f_valid, f_empty, f_uf, f_count); end
        tick();
        n_cmp++; if (f_uf !== 1'b1) begin n_bad++; $display("FAIL ff_underflow: got %b want 1", f_uf); end
        rd_en_f = 1'b0;
        tick();
        n_cmp++; if (f_uf !== 1'b0 || f_rd_ptr_gray !== 4'b0001) begin n_bad++; $display("FAIL ff_uf_end: got uf=%b gray=%b want 0/0001", f_uf, f_rd_ptr_gray); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] w [DEPTH];
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            w[i] = WIDTH'($urandom);
            mem[i] = w[i];
        end
        wr_ptr_gray = 4'b1100;
        repeat (3) tick();
        rd_en_f = 1'b1;
        #1;
        for (int k = 0; k < DEPTH; k++) begin
            n_cmp++; if (f_valid !== 1'b1 || f_data !== w[k]) begin n_bad++; $display("FAIL b2b_word%0d: got %b/%h want 1/%h", k, f_valid, f_data, w[k]); end
            if (k < DEPTH - 1) begin
                n_cmp++; if (f_ren !== 1'b1 || f_raddr !== 3'(k + 1)) begin n_bad++; $display("FAIL b2b_addr%0d: got %b/%0d want 1/%0d", k, f_ren, f_raddr, k + 1); end
            end else begin
                n_cmp++; if (f_ren !== 1'b0) begin n_bad++; $display("FAIL b2b_last_ren: got %b want 0", f_ren); end
            end
            tick();
        end
        n_cmp++; if (f_valid !== 1'b0 || f_empty !== 1'b1) begin n_bad++; $display("FAIL b2b_drained: got v=%b e=%b want 0/1", f_valid, f_empty); end
        n_cmp++; if (f_rd_ptr_gray !== 4'b1100) begin n_bad++; $display("FAIL b2b_gray: got %b want 1100", f_rd_ptr_gray); end
        rd_en_f = 1'b0;
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] w [4];
        for (int i = 0; i < 4; i++) begin
            w[i] = WIDTH'($urandom);
            mem[i] = w[i];
        end
        wr_ptr_gray = 4'b1010;
        tick();
        tick();
        n_cmp++; if (f_ren !== 1'b1 || f_raddr !== 3'd0 || f_count !== 5'd4) begin
            n_bad++; $display("FAIL wrap_start: got ren=%b addr=%0d cnt=%0d want 1/0/4", f_ren, f_raddr, f_count); end
        tick();
        tick();
        n_cmp++; if (f_valid !== 1'b1 || f_data !== w[0] || f_count !== 5'd4 || f_ae !== 1'b0) begin
            n_bad++; $display("FAIL wrap_hold: got v=%b d=%h cnt=%0d ae=%b want 1/%h/4/0", f_valid, f_data, f_count, f_ae, w[0]); end
        rd_en_f = 1'b1;
        #1;
        for (int k = 1; k < 4; k++) begin
            n_cmp++; if (f_ren !== 1'b1 || f_raddr !== 3'(k)) begin n_bad++; $display("FAIL wrap_addr%0d: got %b/%0d want 1/%0d", k, f_ren, f_raddr, k); end
            tick();
            n_cmp++; if (f_valid !== 1'b1 || f_data !== w[k]) begin n_bad++; $display("FAIL wrap_word%0d: got %b/%h want 1/%h", k, f_valid, f_data, w[k]); end
            n_cmp++; if (f_count !== 5'(4 - k) || f_ae !== ((4 - k) <= AE)) begin
                n_bad++; $display("FAIL wrap_count%0d: got %0d/%b want %0d/%b", k, f_count, f_ae, 4 - k, (4 - k) <= AE); end
        end
        tick();
        n_cmp++; if (f_valid !== 1'b0 || f_count !== 5'd0 || f_empty !== 1'b1 || f_ae !== 1'b1) begin
            n_bad++; $display("FAIL wrap_end: got v=%b cnt=%0d e=%b ae=%b want 0/0/1/1", f_valid, f_count, f_empty, f_ae); end
        n_cmp++; if (f_rd_ptr_gray !== 4'b1010) begin n_bad++; $display("FAIL wrap_gray: got %b want 1010", f_rd_ptr_gray); end
        rd_en_f = 1'b0;
    endtask

    task automatic test_std_underflow();
        logic [WIDTH-1:0] w;
        do_reset();
        rd_en_s = 1'b1;
        #1;
        n_cmp++; if (s_ren !== 1'b0) begin n_bad++; $display("FAIL std_uf_ren: got %b want 0", s_ren); end
        tick();
        n_cmp++; if (s_uf !== 1'b1 || s_valid !== 1'b0) begin n_bad++; $display("FAIL std_uf_pulse: got uf=%b v=%b want 1/0", s_uf, s_valid); end
        rd_en_s = 1'b0;
        tick();
        n_cmp++; if (s_uf !== 1'b0 || s_rd_ptr_gray !== 4'b0000) begin n_bad++; $display("FAIL std_uf_end: got uf=%b gray=%b want 0/0000", s_uf, s_rd_ptr_gray); end
        w = WIDTH'($urandom);
        mem[0] = w;
        wr_ptr_gray = 4'b0001;
        tick();
        tick();
        n_cmp++; if (s_count !== 5'd1 || s_empty !== 1'b0) begin n_bad++; $display("FAIL std_level: got %0d/%b want 1/0", s_count, s_empty); end
        rd_en_s = 1'b1;
        #1;
        n_cmp++; if (s_ren !== 1'b1) begin n_bad++; $display("FAIL std_ren: got %b want 1", s_ren); end
        tick();
        n_cmp++; if (s_valid !== 1'b1 || s_data !== w || s_uf !== 1'b0 || s_empty !== 1'b1) begin
            n_bad++; $display("FAIL std_read: got v=%b d=%h uf=%b e=%b want 1/%h/0/1", s_valid, s_data, s_uf, s_empty, w); end
        rd_en_s = 1'b0;
        tick();
        n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL std_valid_drop: got %b want 0", s_valid); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        mem[0] = WIDTH'($urandom);
        mem[1] = WIDTH'($urandom);
        wr_ptr_gray = 4'b0011;
        repeat (4) tick();
        n_cmp++; if (f_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre: got %b want 1", f_valid); end
        reset = 1'b0;
        wr_ptr_gray = '0;
        tick();
        n_cmp++; if (f_valid !== 1'b0 || f_rd_ptr_gray !== 4'b0000 || f_empty !== 1'b1 || f_count !== 5'd0) begin
            n_bad++; $display("FAIL mid_reset: got v=%b gray=%b e=%b cnt=%0d want 0/0000/1/0", f_valid, f_rd_ptr_gray, f_empty, f_count); end
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++; if (f_valid !== 1'b0 || f_ren !== 1'b0) begin n_bad++; $display("FAIL mid_idle: got v=%b ren=%b want 0/0", f_valid, f_ren); end
    endtask

    // Occupancy model: written/issued/popped word counts with the write count seen SYNC cycles late.
    task automatic test_random();
        int   wr_n, f_iss, f_pop, s_iss, syn_out, cnt_e, wr_pct, rd_pct;
        int   syn_pipe [SYNC];
        logic f_v, f_ufe, s_v, s_ufe, f_av, s_av, f_issue, s_issue;
        logic [WIDTH-1:0] s_de;
        do_reset();
        wr_n = 0; f_iss = 0; f_pop = 0; s_iss = 0;
        f_v = 1'b0; f_ufe = 1'b0; s_v = 1'b0; s_ufe = 1'b0; s_de = '0;
        for (int i = 0; i < SYNC; i++) syn_pipe[i] = 0;
        for (int c = 0; c < 400; c++) begin
            case (c / 100)
                0: begin wr_pct = 80; rd_pct = 30; end
                1: begin wr_pct = 30; rd_pct = 80; end
                2: begin wr_pct = 60; rd_pct = 60; end
                default: begin wr_pct = 95; rd_pct = 90; end
            endcase
            syn_out = syn_pipe[SYNC-1];
            cnt_e = syn_out - f_iss + int'(f_v);
            n_cmp++; if (f_valid !== f_v) begin n_bad++; $display("FAIL rnd_f_valid c%0d: got %b want %b", c, f_valid, f_v); end
            if (f_v) begin
                n_cmp++; if (f_data !== dlog[f_pop]) begin n_bad++; $display("FAIL rnd_f_data c%0d: got %h want %h", c, f_data, dlog[f_pop]); end
            end
            n_cmp++; if (f_count !== 5'(cnt_e) || f_empty !== !f_v || f_ae !== (cnt_e <= AE)) begin
                n_bad++; $display("FAIL rnd_f_status c%0d: got cnt=%0d e=%b ae=%b want %0d/%b/%b", c, f_count, f_empty, f_ae, cnt_e, !f_v, cnt_e <= AE); end
            n_cmp++; if (f_uf !== f_ufe || f_rd_ptr_gray !== to_gray(f_iss)) begin
                n_bad++; $display("FAIL rnd_f_ptr c%0d: got uf=%b gray=%b want %b/%b", c, f_uf, f_rd_ptr_gray, f_ufe, to_gray(f_iss)); end
            cnt_e = syn_out - s_iss;
            n_cmp++; if (s_valid !== s_v || (s_v && s_data !== s_de)) begin
                n_bad++; $display("FAIL rnd_s_data c%0d: got %b/%h want %b/%h", c, s_valid, s_data, s_v, s_de); end
            n_cmp++; if (s_count !== 5'(cnt_e) || s_empty !== (cnt_e == 0) || s_ae !== (cnt_e <= AE)) begin
                n_bad++; $display("FAIL rnd_s_status c%0d: got cnt=%0d e=%b ae=%b want %0d", c, s_count, s_empty, s_ae, cnt_e); end
            n_cmp++; if (s_uf !== s_ufe || s_rd_ptr_gray !== to_gray(s_iss)) begin
                n_bad++; $display("FAIL rnd_s_ptr c%0d: got uf=%b gray=%b want %b/%b", c, s_uf, s_rd_ptr_gray, s_ufe, to_gray(s_iss)); end

            if ((wr_n - ((f_pop < s_iss) ? f_pop : s_iss)) < DEPTH && $urandom_range(99) < wr_pct) begin
                dlog[wr_n] = WIDTH'($urandom);
                mem[wr_n % DEPTH] = dlog[wr_n];
                wr_n++;
                wr_ptr_gray = to_gray(wr_n);
            end
            rd_en_f = ($urandom_range(99) < rd_pct);
            rd_en_s = ($urandom_range(99) < rd_pct);
            #1;
            f_av = (syn_out > f_iss);
            f_issue = f_av && (!f_v || rd_en_f);
            n_cmp++; if (f_ren !== f_issue || (f_issue && f_raddr !== 3'(f_iss % DEPTH))) begin
                n_bad++; $display("FAIL rnd_f_ren c%0d: got %b/%0d want %b/%0d", c, f_ren, f_raddr, f_issue, f_iss % DEPTH); end
            s_av = (syn_out > s_iss);
            s_issue = s_av && rd_en_s;
            n_cmp++; if (s_ren !== s_issue || (s_issue && s_raddr !== 3'(s_iss % DEPTH))) begin
                n_bad++; $display("FAIL rnd_s_ren c%0d: got %b/%0d want %b/%0d", c, s_ren, s_raddr, s_issue, s_iss % DEPTH); end

            f_ufe = rd_en_f && !f_v;
            if (f_v && rd_en_f) f_pop++;
            f_v = f_av || (f_v && !rd_en_f);
            if (f_issue) f_iss++;
            s_ufe = rd_en_s && !s_av;
            s_v = s_issue;
            if (s_issue) begin
                s_de = dlog[s_iss];
                s_iss++;
            end
            for (int i = SYNC - 1; i > 0; i--) syn_pipe[i] = syn_pipe[i-1];
            syn_pipe[0] = wr_n;
            tick();
        end
        rd_en_f = 1'b0;
        rd_en_s = 1'b0;
    endtask

    initial begin
        reset = 1'b0; rd_en_f = 1'b0; rd_en_s = 1'b0; wr_ptr_gray = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_fwft_first();
        test_back_to_back();
        test_wrap();
        test_std_underflow();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/async_fifo_rd_ctrl.md
# async_fifo_rd_ctrl

Parametrised read-domain controller for the dual-clock FIFO. It synchronises the Gray-coded write pointer into `rd_clk`, owns the read pointer, and drives the RAM read port. It presents data in standard or first-word-fall-through (FWFT) mode and reports occupancy, almost-empty and underflow. It pairs with the write-domain controller and a registered-read dual-port RAM.

## Interface
- `DEPTH`, 8: entries; power of 2, ≥4. `AW` = log2(DEPTH); pointers are AW+1 bits.
- `WIDTH`, 8: data width.
- `SYNC_STAGES`, 2: write-pointer synchroniser depth, 2..4.
- `AE_THRESH`, 2: `almost_empty` asserts when `rd_count` ≤ AE_THRESH.
- `FWFT`, 1: 1 selects FWFT mode; 0 selects standard mode.

Ports:
- `rd_clk`  in  1  read clock.
- `reset`  in  1  reset; synchronous, active-low.
- `wr_ptr_gray`  in  AW+1  Gray write pointer, a write-domain flop output.
- `rd_ptr_gray`  out  AW+1  registered Gray read pointer, sent to the write domain.
- `ram_raddr`  out  AW  RAM read address, equal to rd_ptr_bin[AW-1:0].
- `ram_ren`  out  1  RAM read strobe.
- `ram_rdata`  in  WIDTH  RAM data, valid only in the cycle after `ram_ren`.
- `rd_en`  in  1  read request (standard mode) or pop (FWFT mode).
- `rd_data`  out  WIDTH  read data.
- `rd_valid`  out  1  `rd_data` is valid.
- `empty`  out  1  no data available.
- `almost_empty`  out  1  low watermark.
- `rd_count`  out  AW+2  words available to the reader (max DEPTH+1 in FWFT mode).
- `underflow`  out  1  one-cycle pulse on an illegal read.

## Operation
- Synchroniser: `wr_ptr_gray` passes through SYNC_STAGES flops, then Gray→binary gives `wr_bin_s`. `ram_avail` = (`wr_bin_s` != `rd_ptr_bin`). `ram_level` = `wr_bin_s` − `rd_ptr_bin`, modulo 2^(AW+1).
- Each read issue asserts `ram_ren` and increments `rd_ptr_bin`, wrapping modulo 2^(AW+1). `rd_ptr_gray` is registered from the next binary value, giving a single-bit change per increment.
- `ram_ren` is combinational from registered state and `rd_en`, and is gated low while `reset`=0.

Standard mode (FWFT=0):
- `rd_en`·`ram_avail` issues a read.
- On the next cycle `rd_valid`=1 and `rd_data`=`ram_rdata`.
- `empty` = !`ram_avail`. `rd_count` = `ram_level`.
- `rd_en`·!`ram_avail`: no issue, pointer unchanged, `underflow` pulses the next cycle.

FWFT mode uses a 3-state FSM:
- IDLE: `rd_valid`=0.
  - If `ram_avail`: issue a read and go to FETCH.
- FETCH: `rd_valid`=1, `rd_data`=`ram_rdata`.
  - `rd_en` and `ram_avail`: issue a read, stay in FETCH.
  - `rd_en` and !`ram_avail`: go to IDLE.
  - !`rd_en`: capture `ram_rdata` into `hold_q`, go to HOLD.
- HOLD: `rd_valid`=1, `rd_data`=`hold_q`.
  - `rd_en` and `ram_avail`: issue a read, go to FETCH.
  - `rd_en` and !`ram_avail`: go to IDLE.
  - !`rd_en`: stay in HOLD.
- Status: `empty` = !`rd_valid`. `rd_count` = `ram_level` + `rd_valid`. A pop while `rd_valid`=0 pulses `underflow` and is otherwise ignored.
- `almost_empty` = (`rd_count` ≤ AE_THRESH) in both modes.
- `rd_count`, `empty` and `almost_empty` depend on registered state only; there is no path from `rd_en`.

## Timing
- Reset (`reset`=0 at an edge) clears the following on that edge:
  - `rd_ptr_bin`, `rd_ptr_gray` and the synchroniser chain → 0.
  - FSM → IDLE; `hold_q`, `rd_data` → 0.
  - `rd_valid`=0, `underflow`=0, `rd_count`=0, `empty`=1, `almost_empty`=1, `ram_ren`=0.
- Reset mid-operation drops any in-flight word. The write domain must be reset concurrently.
- Write-pointer change to `ram_avail`: SYNC_STAGES `rd_clk` edges.
- FWFT: `rd_valid` rises 1 edge after the synchroniser output updates, i.e. SYNC_STAGES+1 edges after `wr_ptr_gray` changes.
- Standard mode: `rd_en` sampled at edge N gives `rd_valid` and data in cycle N+1.
- FWFT with `rd_en` held high and data available: one word per cycle, with no bubble.
- `rd_ptr_gray` updates on the same edge as the read issue. The write side sees it after its own synchroniser delay.
- Wrap: the pointer goes 2^(AW+1)−1 → 0 and the address wraps DEPTH−1 → 0. `rd_count` stays correct across the wrap via modular subtraction.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `wr_ptr_gray`=4'b0101.
  - Expect all outputs at their reset values and `ram_ren`=0.
  - After release, `rd_count`=6 and `rd_valid`=1 at edge SYNC_STAGES+1.
- FWFT first word: `wr_ptr_gray` 0→4'b0001, `ram_rdata`=8'hA5.
  - Expect `rd_valid`=1 at edge 3 with `rd_data`=A5, `rd_count`=1, `empty`=0, `almost_empty`=1.
  - `rd_valid` holds with `rd_data`=A5 while `rd_en`=0.
- Back-to-back: `wr_ptr_gray`=4'b1100 (8 words), `rd_en` held at 1.
  - Expect 8 consecutive `rd_valid` cycles, `ram_raddr` 0..7, final `rd_ptr_gray`=4'b1100, then `empty`=1.
- Wrap: continuing from back-to-back, `wr_ptr_gray`=4'b1010 (binary 12).
  - Expect reads from addresses 0..3 with `rd_ptr_bin` 8→12, `rd_count` 4→0, `almost_empty` rising when `rd_count`=2.
- Underflow (FWFT=0): with the FIFO empty, `rd_en`=1 for 1 cycle.
  - Expect `ram_ren`=0, `underflow`=1 for exactly one cycle, pointer unchanged.
- Mid-operation reset: in HOLD with `rd_valid`=1, drive `reset`=0 for 1 cycle.
  - Next edge: `rd_valid`=0, `rd_ptr_gray`=0, FSM in IDLE.
